// File: rtl/regfile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : regfile_pkg
// Purpose : Shared FSM state encoding and width helper for the register bank.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package regfile_pkg;

  // INIT sweeps zeros through the array; RUN is normal operation.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ceiling log2 for deriving address widths (returns 1 for a value of 2).
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : regfile_scoreboard
// Purpose : One pending bit per register. Set marks a register as awaiting a
//           result, a write clears it, flush clears everything.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  localparam int ADDR_W   = clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic              pend1_o,
  output logic              pend2_o
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  // Next pending state: clear first so a same-cycle set wins, flush beats all.
  always_comb begin
    pend_d = pend_q;
    if (clr_i) begin
      pend_d[clr_addr_i] = 1'b0;
    end
    if (set_i) begin
      pend_d[set_addr_i] = 1'b1;
    end
    if (flush_i) begin
      pend_d = '0;
    end
  end

  // Pending bit register with synchronous clear on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend1_o = pend_q[rd_addr1_i];
  assign pend2_o = pend_q[rd_addr2_i];

endmodule
`default_nettype wire

// File: rtl/regfile_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : regfile_bank
// Purpose : Two-read / one-write register file with optional hard-zero r0,
//           optional write-to-read bypass, a pending-result scoreboard and a
//           post-reset zeroing sweep (the array itself has no reset).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module regfile_bank
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  bit ZERO_REG = 1'b1,
  parameter  bit BYPASS   = 1'b1,
  localparam int ADDR_W   = clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic              flush,
  output logic              read_pend1,
  output logic              read_pend2,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic              w_init;
  logic              w_run;
  logic              w_wr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_set;
  logic [ADDR_W-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];
  logic              w_sb_pend [2];
  logic              w_rpend [2];

  // State and sweep index register; reset restarts the sweep from zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: advance the sweep index, leave INIT once the last entry is zeroed.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == C_LAST_IDX) begin
        state_d = ST_RUN;
      end
    end
  end

  // FSM outputs.
  always_comb begin
    w_init    = (state_q == ST_INIT);
    w_run     = (state_q == ST_RUN);
    init_busy = w_init;
  end

  // Architectural write: RUN only, never r0 when hard-wired, dropped under reset.
  assign w_wr = w_run && write_en && !reset &&
                !(ZERO_REG && (write_addr == '0));

  // Single memory write port shared between the sweep and normal writes.
  assign w_mem_we    = !reset && (w_init || w_wr);
  assign w_mem_addr  = w_init ? idx_q : write_addr;
  assign w_mem_wdata = w_init ? '0 : write_data;

  // Register array write port (no reset so the array can map to memory).
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      mem_q[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign w_set = w_run && pend_set && !(ZERO_REG && (pend_addr == '0));

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .set_i      (w_set),
    .set_addr_i (pend_addr),
    .clr_i      (w_wr),
    .clr_addr_i (write_addr),
    .flush_i    (flush),
    .rd_addr1_i (read_addr1),
    .rd_addr2_i (read_addr2),
    .pend1_o    (w_sb_pend[0]),
    .pend2_o    (w_sb_pend[1])
  );

  assign w_raddr[0] = read_addr1;
  assign w_raddr[1] = read_addr2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    // Read port: zero during INIT and for hard r0, optional same-cycle bypass.
    always_comb begin
      w_rdata[p] = mem_q[w_raddr[p]];
      w_rpend[p] = w_sb_pend[p];
      if (BYPASS && w_wr && (w_raddr[p] == write_addr)) begin
        w_rdata[p] = write_data;
      end
      if (!w_run || (ZERO_REG && (w_raddr[p] == '0))) begin
        w_rdata[p] = '0;
        w_rpend[p] = 1'b0;
      end
    end
  end

  assign read_data1 = w_rdata[0];
  assign read_data2 = w_rdata[1];
  assign read_pend1 = w_rpend[0];
  assign read_pend2 = w_rpend[1];

endmodule
`default_nettype wire

// File: tb/tb_regfile_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_regfile_bank
// Purpose : Self-checking bench for regfile_bank; a bypassing and a
//           non-bypassing instance share stimulus and one reference model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_regfile_bank;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clock = 1'b1;
  logic          reset;
  logic [AW-1:0] read_addr1, read_addr2, write_addr, pend_addr;
  logic [DW-1:0] write_data;
  logic          write_en, pend_set, flush;

  logic [DW-1:0] rd1, rd2, rd1_nb, rd2_nb;
  logic          rp1, rp2, rp1_nb, rp2_nb, busy, busy_nb;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] m_mem [NR];
  bit            m_pend [NR];
  int            m_init_left = 0;
  bit            m_valid = 1'b0;

  always #5 clock = ~clock;

  regfile_bank u_dut (
    .clock(clock), .reset(reset),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1), .read_data2(rd2),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .flush(flush),
    .read_pend1(rp1), .read_pend2(rp2), .init_busy(busy)
  );

  regfile_bank #(.BYPASS(1'b0)) u_dut_nb (
    .clock(clock), .reset(reset),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1_nb), .read_data2(rd2_nb),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .flush(flush),
    .read_pend1(rp1_nb), .read_pend2(rp2_nb), .init_busy(busy_nb)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (m_init_left > 0) return '0;
    if (a == 0) return '0;
    if (byp && write_en && !reset && (a == write_addr)) return write_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    if (m_init_left > 0) return 1'b0;
    if (a == 0) return 1'b0;
    return m_pend[a];
  endfunction

  // One clock: check combinational outputs mid-cycle, then advance the model.
  task automatic cycle();
    @(negedge clock);
    if (m_valid) begin
      check_val("init_busy", 64'(busy), 64'(m_init_left > 0));
      check_val("init_busy_nb", 64'(busy_nb), 64'(m_init_left > 0));
      check_val("rd1", 64'(rd1), 64'(exp_rd(read_addr1, 1'b1)));
      check_val("rd2", 64'(rd2), 64'(exp_rd(read_addr2, 1'b1)));
      check_val("rd1_nb", 64'(rd1_nb), 64'(exp_rd(read_addr1, 1'b0)));
      check_val("rd2_nb", 64'(rd2_nb), 64'(exp_rd(read_addr2, 1'b0)));
      check_val("pend1", 64'(rp1), 64'(exp_pend(read_addr1)));
      check_val("pend2", 64'(rp2), 64'(exp_pend(read_addr2)));
      check_val("pend1_nb", 64'(rp1_nb), 64'(exp_pend(read_addr1)));
    end
    @(posedge clock);
    if (reset) begin
      m_init_left = NR;
      for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
      m_valid = 1'b1;
    end else if (m_init_left > 0) begin
      m_mem[NR - m_init_left] = '0;
      m_init_left--;
    end else begin
      if (write_en && write_addr != 0) begin
        m_mem[write_addr]  = write_data;
        m_pend[write_addr] = 1'b0;
      end
      if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
      if (flush) for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    reset    = 1'b0;
    write_en = 1'b0;
    pend_set = 1'b0;
    flush    = 1'b0;
  endtask

  int cnt;

  initial begin
    reset = 1'b1; write_en = 1'b0; pend_set = 1'b0; flush = 1'b0;
    read_addr1 = '0; read_addr2 = '0; write_addr = '0; pend_addr = '0; write_data = '0;
    for (int i = 0; i < NR; i++) m_mem[i] = 32'hBAD0_0000 + i;
    cycle();

    // Sweep length after reset, then every register reads zero
    idle();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      read_addr1 = AW'(i % NR);
      read_addr2 = AW'(NR - 1 - (i % NR));
      #3;
      if (busy === 1'b1) cnt++;
      cycle();
    end
    check_val("init_cycles", 64'(cnt), 64'd32);
    for (int i = 0; i < NR; i++) begin
      read_addr1 = AW'(i);
      read_addr2 = AW'(NR - 1 - i);
      #3;
      check_val("zero_after_init", 64'(rd1), 64'd0);
      cycle();
    end

    // Same-cycle write/read of r5: bypass vs no bypass
    write_en = 1'b1; write_addr = 5; write_data = 32'hDEADBEEF; read_addr1 = 5;
    #3;
    check_val("bypass_same_cycle", 64'(rd1), 64'hDEADBEEF);
    check_val("nobypass_same_cycle", 64'(rd1_nb), 64'd0);
    cycle();
    idle();
    #3;
    check_val("nobypass_next_cycle", 64'(rd1_nb), 64'hDEADBEEF);
    cycle();

    // Hard-wired r0
    write_en = 1'b1; write_addr = 0; write_data = 32'h1234;
    cycle();
    idle(); read_addr1 = 0;
    #3;
    check_val("r0_read", 64'(rd1), 64'd0);
    pend_set = 1'b1; pend_addr = 0;
    cycle();
    idle();
    #3;
    check_val("r0_pend", 64'(rp1), 64'd0);
    cycle();

    // Pending set, write+set same cycle keeps it, lone write clears it
    pend_set = 1'b1; pend_addr = 7;
    cycle();
    write_en = 1'b1; write_addr = 7; write_data = 32'h77; pend_set = 1'b1; pend_addr = 7;
    read_addr1 = 7;
    cycle();
    idle();
    #3;
    check_val("pend_newer_wins", 64'(rp1), 64'd1);
    cycle();
    write_en = 1'b1; write_addr = 7; write_data = 32'h78;
    cycle();
    idle();
    #3;
    check_val("pend_cleared_by_write", 64'(rp1), 64'd0);
    cycle();

    // Flush beats a simultaneous set
    pend_set = 1'b1; pend_addr = 3; cycle();
    pend_set = 1'b1; pend_addr = 9; cycle();
    idle(); read_addr1 = 3; read_addr2 = 9;
    #3;
    check_val("pend_r3_set", 64'(rp1), 64'd1);
    check_val("pend_r9_set", 64'(rp2), 64'd1);
    flush = 1'b1; pend_set = 1'b1; pend_addr = 4;
    cycle();
    idle();
    #3;
    check_val("flush_r3", 64'(rp1), 64'd0);
    check_val("flush_r9", 64'(rp2), 64'd0);
    cycle();
    read_addr1 = 4;
    #3;
    check_val("flush_beats_set", 64'(rp1), 64'd0);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      write_en   = 1'($urandom_range(0, 1));
      write_addr = AW'($urandom);
      write_data = $urandom;
      pend_set   = ($urandom_range(0, 2) == 0);
      pend_addr  = AW'($urandom);
      flush      = ($urandom_range(0, 19) == 0);
      read_addr1 = ($urandom_range(0, 2) == 0) ? write_addr : AW'($urandom);
      read_addr2 = ($urandom_range(0, 2) == 0) ? pend_addr : AW'($urandom);
      cycle();
    end
    idle();

    // Reset mid-sweep restarts it; a write during INIT is lost
    reset = 1'b1; cycle();
    reset = 1'b0;
    repeat (10) cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    write_en = 1'b1; write_addr = 12; write_data = 32'h55;
    cnt = 0;
    for (int i = 0; i < 34; i++) begin
      if (i == 5) write_en = 1'b0;
      #3;
      if (busy === 1'b1) cnt++;
      cycle();
    end
    check_val("restart_init_cycles", 64'(cnt), 64'd32);
    idle(); read_addr1 = 12;
    #3;
    check_val("init_write_lost", 64'(rd1), 64'd0);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
